// File: rtl/jtframe_cen24_pkg.sv
// Shared types and decode constants for the 24 MHz clock-enable generator.
// The enable bundle is kept as one packed struct so it can be registered in a single step.
package jtframe_cen24_pkg;

  localparam logic [2:0] CNT6_LAST = 3'd5;

  // Phase points within the 8-clock 3 MHz period, relative to cen3 at 0
  localparam logic [2:0] PH3_B   = 3'd4;
  localparam logic [2:0] PH3_Q   = 3'd6;
  localparam logic [2:0] PH3_QB  = 3'd2;
  localparam logic [1:0] PH6_B   = 2'd2;
  localparam logic [3:0] PH1P5_B = 4'd8;
  localparam logic [2:0] PH8_B   = 3'd3;

  typedef struct packed {
    logic cen12;
    logic cen8;
    logic cen6;
    logic cen4;
    logic cen3;
    logic cen3q;
    logic cen1p5;
    logic cen12b;
    logic cen6b;
    logic cen3b;
    logic cen3qb;
    logic cen1p5b;
  } cen_t;

endpackage

// File: rtl/jtframe_cen24.sv
// Clock-enable generator for a 24 MHz system clock: 12/8/6/4/3/1.5 MHz pulses
// plus quarter-period and 180-degree shifted variants, all registered.
module jtframe_cen24
  import jtframe_cen24_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic cen12,
  output logic cen8,
  output logic cen6,
  output logic cen4,
  output logic cen3,
  output logic cen3q,
  output logic cen1p5,
  output logic cen12b,
  output logic cen6b,
  output logic cen3b,
  output logic cen3qb,
  output logic cen1p5b
);

  logic [3:0] cnt16_q, cnt16_d;
  logic [2:0] cnt6_q,  cnt6_d;
  cen_t       cen_q,   cen_d;

  // Binary divisors cover 2/4/8/16; the mod-6 counter covers 3 and 6
  always_comb begin
    cnt16_d = cnt16_q + 4'd1;
    cnt6_d  = (cnt6_q == CNT6_LAST) ? 3'd0 : cnt6_q + 3'd1;

    cen_d         = '0;
    cen_d.cen12   = ~cnt16_q[0];
    cen_d.cen12b  =  cnt16_q[0];
    cen_d.cen6    = (cnt16_q[1:0] == 2'd0);
    cen_d.cen6b   = (cnt16_q[1:0] == PH6_B);
    cen_d.cen3    = (cnt16_q[2:0] == 3'd0);
    cen_d.cen3b   = (cnt16_q[2:0] == PH3_B);
    cen_d.cen3q   = (cnt16_q[2:0] == PH3_Q);
    cen_d.cen3qb  = (cnt16_q[2:0] == PH3_QB);
    cen_d.cen1p5  = (cnt16_q == 4'd0);
    cen_d.cen1p5b = (cnt16_q == PH1P5_B);
    cen_d.cen8    = (cnt6_q == 3'd0) || (cnt6_q == PH8_B);
    cen_d.cen4    = (cnt6_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt16_q <= '0;
      cnt6_q  <= '0;
      cen_q   <= '0;
    end else begin
      cnt16_q <= cnt16_d;
      cnt6_q  <= cnt6_d;
      cen_q   <= cen_d;
    end
  end

  assign cen12   = cen_q.cen12;
  assign cen8    = cen_q.cen8;
  assign cen6    = cen_q.cen6;
  assign cen4    = cen_q.cen4;
  assign cen3    = cen_q.cen3;
  assign cen3q   = cen_q.cen3q;
  assign cen1p5  = cen_q.cen1p5;
  assign cen12b  = cen_q.cen12b;
  assign cen6b   = cen_q.cen6b;
  assign cen3b   = cen_q.cen3b;
  assign cen3qb  = cen_q.cen3qb;
  assign cen1p5b = cen_q.cen1p5b;

endmodule

// File: tb/tb_jtframe_cen24.sv
// Directed bench for jtframe_cen24: reset, per-phase patterns, pulse counts,
// phase offsets, exclusion/coincidence and mid-run reset.
module tb_jtframe_cen24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen12, cen8, cen6, cen4, cen3, cen3q, cen1p5;
  logic cen12b, cen6b, cen3b, cen3qb, cen1p5b;

  int checks = 0;
  int errors = 0;

  jtframe_cen24 dut (
    .clk     (clk),
    .rst     (rst),
    .cen12   (cen12),
    .cen8    (cen8),
    .cen6    (cen6),
    .cen4    (cen4),
    .cen3    (cen3),
    .cen3q   (cen3q),
    .cen1p5  (cen1p5),
    .cen12b  (cen12b),
    .cen6b   (cen6b),
    .cen3b   (cen3b),
    .cen3qb  (cen3qb),
    .cen1p5b (cen1p5b)
  );

  always #5 clk = ~clk;

  // Order: cen12 cen8 cen6 cen4 cen3 cen3q cen1p5 cen12b cen6b cen3b cen3qb cen1p5b
  function automatic logic [11:0] outs();
    return {cen12, cen8, cen6, cen4, cen3, cen3q, cen1p5,
            cen12b, cen6b, cen3b, cen3qb, cen1p5b};
  endfunction

  // Expected vector k cycles after the first post-release edge (k=0 is phase 0)
  function automatic logic [11:0] expv(int k);
    logic [11:0] v;
    v[11] = (k % 2)  == 0;
    v[10] = (k % 3)  == 0;
    v[9]  = (k % 4)  == 0;
    v[8]  = (k % 6)  == 0;
    v[7]  = (k % 8)  == 0;
    v[6]  = (k % 8)  == 6;
    v[5]  = (k % 16) == 0;
    v[4]  = (k % 2)  == 1;
    v[3]  = (k % 4)  == 2;
    v[2]  = (k % 8)  == 4;
    v[1]  = (k % 8)  == 2;
    v[0]  = (k % 16) == 8;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int cnt [12];
  int first_rise [12];
  int last8;
  int bad_per8, bad_excl, bad_coin, bad_c4;
  logic [11:0] v;

  initial begin
    // Reset held for 5 clocks
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("reset_zero_%0d", i), int'(outs()), 0);
    end

    rst = 1'b0;
    tick();
    chk("release_first", int'(outs()), int'(12'b1111_1010_0000));

    for (int j = 0; j < 12; j++) begin
      cnt[j] = 0;
      first_rise[j] = -1;
    end
    last8 = -1;
    bad_per8 = 0; bad_excl = 0; bad_coin = 0; bad_c4 = 0;

    // 1000 cycles from phase 0: pattern checks and pulse counts over the first 480
    for (int k = 0; k < 1000; k++) begin
      if (k > 0) tick();
      v = outs();
      if (k < 48) chk($sformatf("pattern_k%0d", k), int'(v), int'(expv(k)));
      if (k < 480) begin
        for (int j = 0; j < 12; j++) begin
          if (v[j]) begin
            cnt[j]++;
            if (first_rise[j] < 0) first_rise[j] = k;
          end
        end
      end
      if (cen8) begin
        if (last8 >= 0 && (k - last8) != 3) bad_per8++;
        last8 = k;
      end
      if ((cen12 & cen12b) | (cen6 & cen6b) | (cen3 & cen3b) |
          (cen3 & cen3q) | (cen1p5 & cen1p5b)) bad_excl++;
      if (cen1p5 && !(cen3 && cen6 && cen12)) bad_coin++;
      if (cen4 && !cen8) bad_c4++;
    end

    chk("count_cen12",   cnt[11], 240);
    chk("count_cen8",    cnt[10], 160);
    chk("count_cen6",    cnt[9],  120);
    chk("count_cen4",    cnt[8],  80);
    chk("count_cen3",    cnt[7],  60);
    chk("count_cen3q",   cnt[6],  60);
    chk("count_cen1p5",  cnt[5],  30);
    chk("count_cen12b",  cnt[4],  240);
    chk("count_cen6b",   cnt[3],  120);
    chk("count_cen3b",   cnt[2],  60);
    chk("count_cen3qb",  cnt[1],  60);
    chk("count_cen1p5b", cnt[0],  30);

    // Rise positions relative to base enables at phase 0
    chk("lead_cen3q",   8 - first_rise[6], 2);
    chk("lag_cen3qb",   first_rise[1], 2);
    chk("lag_cen3b",    first_rise[2], 4);
    chk("lag_cen1p5b",  first_rise[0], 8);
    chk("lag_cen6b",    first_rise[3], 2);
    chk("lag_cen12b",   first_rise[4], 1);

    chk("cen8_period3",   bad_per8, 0);
    chk("exclusion",      bad_excl, 0);
    chk("coincide_1p5",   bad_coin, 0);
    chk("cen4_with_cen8", bad_c4,   0);

    // Mid-run reset: fresh start, then rst at clock 37 for 2 clocks
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 1; k < 37; k++) tick();
    chk("pre_midrst_k36", int'(outs()), int'(expv(36)));
    rst = 1'b1;
    tick();
    chk("midrst_zero_0", int'(outs()), 0);
    tick();
    chk("midrst_zero_1", int'(outs()), 0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      chk($sformatf("restart_k%0d", k), int'(outs()), int'(expv(k)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
